// File: rtl/pptree_pkg.sv
// Shared sizing helpers for the pipelined parallel-prefix adder.
// Level and segment counts are derived from operand width and register spacing.
package pptree_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int REG_EVERY_DEF = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic int n_levels(input int w);
        return clog2(w);
    endfunction

    // A width-1 adder still needs one register stage.
    function automatic int n_seg(input int w, input int re);
        int l;
        l = n_levels(w);
        return (l == 0) ? 1 : (l + re - 1) / re;
    endfunction

endpackage

// File: rtl/pptree_cells.sv
// Generic logic cells; tech mapping replaces these bodies.
// The adder datapath instantiates only these for its gates.
module and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module ao21 (
    input  logic a0,
    input  logic a1,
    input  logic b,
    output logic y
);
    assign y = (a0 & a1) | b;
endmodule

module buffer (
    input  logic a,
    output logic y
);
    assign y = a;
endmodule

// File: rtl/pptree_pipe_seg.sv
// One pipeline segment: Kogge-Stone levels LO..HI, then a register slice
// with its own valid bit and ready term.
module pptree_pipe_seg #(
    parameter int WIDTH = 32,
    parameter int LO    = 1,
    parameter int HI    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    output logic             dn_valid,
    input  logic             dn_ready,
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] pt_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o,
    output logic [WIDTH-1:0] pt_o,
    output logic             c_o
);

    localparam int NL = (HI >= LO) ? HI - LO + 1 : 0;

    logic [WIDTH-1:0] gl [NL+1];
    logic [WIDTH-1:0] pl [NL+1];

    assign gl[0] = g_i;
    assign pl[0] = p_i;

    for (genvar j = 0; j < NL; j++) begin : g_lvl
        localparam int D = 1 << (LO + j - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                ao21 u_g (
                    .a0(pl[j][i]),
                    .a1(gl[j][i-D]),
                    .b (gl[j][i]),
                    .y (gl[j+1][i])
                );
                and2 u_p (
                    .a(pl[j][i]),
                    .b(pl[j][i-D]),
                    .y(pl[j+1][i])
                );
            end else begin : g_pass
                buffer u_g (.a(gl[j][i]), .y(gl[j+1][i]));
                buffer u_p (.a(pl[j][i]), .y(pl[j+1][i]));
            end
        end
    end

    // A slot may refill whenever it is empty or its content leaves now.
    assign up_ready = !dn_valid | dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_o  <= '0;
            p_o  <= '0;
            pt_o <= '0;
            c_o  <= 1'b0;
        end else if (up_ready && up_valid) begin
            g_o  <= gl[NL];
            p_o  <= pl[NL];
            pt_o <= pt_i;
            c_o  <= c_i;
        end
    end

endmodule

// File: rtl/pptree_pipe_adder.sv
// Pipelined Kogge-Stone adder with valid/ready flow control.
// Carry-in is folded into bit 0 generate before the prefix tree.
module pptree_pipe_adder
    import pptree_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int REG_EVERY = REG_EVERY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int L    = n_levels(WIDTH);
    localparam int NSEG = n_seg(WIDTH, REG_EVERY);

    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] gc;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pre
        xor2 u_p (.a(a[i]), .b(b[i]), .y(p0[i]));
        and2 u_g (.a(a[i]), .b(b[i]), .y(g0[i]));
        if (i == 0) begin : g_cin
            ao21 u_c (.a0(p0[0]), .a1(cin), .b(g0[0]), .y(gc[0]));
        end else begin : g_nc
            buffer u_c (.a(g0[i]), .y(gc[i]));
        end
    end

    logic [WIDTH-1:0] gs [NSEG+1];
    logic [WIDTH-1:0] ps [NSEG+1];
    logic [WIDTH-1:0] ts [NSEG+1];
    logic             cs [NSEG+1];
    logic             vs [NSEG+1];
    logic             rs [NSEG+1];

    assign gs[0]    = gc;
    assign ps[0]    = p0;
    assign ts[0]    = p0;
    assign cs[0]    = cin;
    assign vs[0]    = in_valid;
    assign rs[NSEG] = out_ready;

    assign in_ready  = rs[0];
    assign out_valid = vs[NSEG];

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LO  = k * REG_EVERY + 1;
        localparam int TOP = (k + 1) * REG_EVERY;
        localparam int HI  = (TOP < L) ? TOP : L;
        pptree_pipe_seg #(
            .WIDTH(WIDTH),
            .LO   (LO),
            .HI   (HI)
        ) u_seg (
            .clk     (clk),
            .rst_n   (rst_n),
            .up_valid(vs[k]),
            .up_ready(rs[k]),
            .dn_valid(vs[k+1]),
            .dn_ready(rs[k+1]),
            .g_i     (gs[k]),
            .p_i     (ps[k]),
            .pt_i    (ts[k]),
            .c_i     (cs[k]),
            .g_o     (gs[k+1]),
            .p_o     (ps[k+1]),
            .pt_o    (ts[k+1]),
            .c_o     (cs[k+1])
        );
    end

    // Sum is a thin xor layer on the final registered carries.
    for (genvar i = 0; i < WIDTH; i++) begin : g_sum
        if (i == 0) begin : g_s0
            xor2 u_s (.a(ts[NSEG][0]), .b(cs[NSEG]), .y(sum[0]));
        end else begin : g_si
            xor2 u_s (.a(ts[NSEG][i]), .b(gs[NSEG][i-1]), .y(sum[i]));
        end
    end

    buffer u_cout (.a(gs[NSEG][WIDTH-1]), .y(cout));

endmodule

// File: tb/tb_pptree_pipe_adder.sv
// Bench for pptree_pipe_adder: directed handshake scenarios plus
// randomized streams scored against plain integer addition.
module tb_pptree_pipe_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic       iv8, ir8, ov8, ordy8, cin8, cout8;
    logic [7:0] a8, b8, sum8;

    pptree_pipe_adder #(.WIDTH(8), .REG_EVERY(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(ordy8),
        .sum(sum8), .cout(cout8)
    );

    logic iv1, ir1, ov1, ordy1, a1, b1, cin1, sum1, cout1;

    pptree_pipe_adder #(.WIDTH(1), .REG_EVERY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(ordy1),
        .sum(sum1), .cout(cout1)
    );

    logic [31:0] ra [3];
    logic [31:0] rb [3];
    logic [31:0] rsum [3];
    logic        rcin [3];
    logic        riv [3];
    logic        rir [3];
    logic        rov [3];
    logic        rordy [3];
    logic        rcout [3];

    for (genvar k = 0; k < 3; k++) begin : g_r
        pptree_pipe_adder #(
            .WIDTH(32),
            .REG_EVERY(k == 0 ? 1 : (k == 1 ? 2 : 5))
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(riv[k]), .in_ready(rir[k]),
            .a(ra[k]), .b(rb[k]), .cin(rcin[k]),
            .out_valid(rov[k]), .out_ready(rordy[k]),
            .sum(rsum[k]), .cout(rcout[k])
        );
    end

    task automatic test_reset();
        rst_n = 1'b0;
        iv8 = 0; ordy8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        iv1 = 0; ordy1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        for (int k = 0; k < 3; k++) begin
            riv[k] = 0; rordy[k] = 0; ra[k] = 0; rb[k] = 0; rcin[k] = 0;
        end
        #2;
        n_checks++;
        if ({ov8, cout8, sum8} !== 10'h0)
            $display("FAIL reset_out8: got %h want 0", {ov8, cout8, sum8});
        else n_pass++;
        n_checks++;
        if ({ov1, rov[0], rov[1], rov[2]} !== 4'h0)
            $display("FAIL reset_valid: got %b want 0000",
                     {ov1, rov[0], rov[1], rov[2]});
        else n_pass++;
        n_checks++;
        if ({rcout[2], rsum[2]} !== 33'h0)
            $display("FAIL reset_out32: got %h want 0", {rcout[2], rsum[2]});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ir8 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ir8);
        else n_pass++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        ordy8 = 1; iv8 = 1; a8 = 8'hFF; b8 = 8'h01; cin8 = 0;
        @(negedge clk);
        iv8 = 0;
        n_checks++;
        if (ov8 !== 1'b0) $display("FAIL basic_early: got %b want 0", ov8);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ov8, cout8, sum8} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL basic_sum: got v%b c%b s%h want v1 c1 s00",
                     ov8, cout8, sum8);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int bad = 0;
        ordy8 = 1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                if (ov8 !== 1'b1 || sum8 !== 8'(8'h12 + c - 2)) bad++;
            end else if (ov8 !== 1'b0) bad++;
            iv8 = (c < 4); a8 = 8'(8'h10 + c); b8 = 8'h01; cin8 = 1;
            #1;
            if (c < 4 && ir8 !== 1'b1) bad++;
        end
        iv8 = 0;
        n_checks++;
        if (bad != 0) $display("FAIL stream: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_stall();
        int fed = 0;
        int moved = 0;
        logic [7:0] res [$];
        ordy8 = 0; b8 = 8'h01; cin8 = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 3 && (ov8 !== 1'b1 || sum8 !== 8'h12)) moved++;
            iv8 = (fed < 4); a8 = 8'(8'h10 + fed);
            #1;
            if (iv8 && ir8) fed++;
        end
        @(negedge clk);
        n_checks++;
        if (ir8 !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", ir8);
        else n_pass++;
        n_checks++;
        if (fed != 2) $display("FAIL stall_accepts: got %0d want 2", fed);
        else n_pass++;
        n_checks++;
        if (moved != 0) $display("FAIL stall_hold: got %0d changes want 0", moved);
        else n_pass++;
        ordy8 = 1;
        for (int c = 0; c < 10; c++) begin
            iv8 = (fed < 4); a8 = 8'(8'h10 + fed);
            #1;
            if (ov8 && ordy8) res.push_back(sum8);
            if (iv8 && ir8) fed++;
            @(negedge clk);
        end
        iv8 = 0;
        n_checks++;
        if (res.size() != 4) $display("FAIL stall_count: got %0d want 4", res.size());
        else n_pass++;
        for (int i = 0; i < res.size() && i < 4; i++) begin
            n_checks++;
            if (res[i] !== 8'(8'h12 + i))
                $display("FAIL stall_order%0d: got %h want %h", i, res[i], 8'(8'h12 + i));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        ordy8 = 0; b8 = 8'h01; cin8 = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            iv8 = 1; a8 = 8'(c + 1);
        end
        @(negedge clk);
        iv8 = 0;
        n_checks++;
        if (ov8 !== 1'b1) $display("FAIL mid_inflight: got %b want 1", ov8);
        else n_pass++;
        rst_n = 0;
        #1;
        n_checks++;
        if ({ov8, sum8} !== 9'h0)
            $display("FAIL mid_reset: got v%b s%h want v0 s00", ov8, sum8);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        ordy8 = 1; iv8 = 1; a8 = 8'h05; b8 = 8'h03; cin8 = 0;
        #1;
        n_checks++;
        if (ir8 !== 1'b1) $display("FAIL mid_ready: got %b want 1", ir8);
        else n_pass++;
        @(negedge clk);
        iv8 = 0;
        n_checks++;
        if (ov8 !== 1'b0) $display("FAIL mid_early: got %b want 0", ov8);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ov8, sum8} !== {1'b1, 8'h08})
            $display("FAIL mid_sum: got v%b s%h want v1 s08", ov8, sum8);
        else n_pass++;
    endtask

    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] exp;
        ordy1 = 1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                v = 3'(i - 1);
                exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
                n_checks++;
                if ({ov1, cout1, sum1} !== {1'b1, exp})
                    $display("FAIL w1_%0d: got v%b %b%b want v1 %b",
                             i - 1, ov1, cout1, sum1, exp);
                else n_pass++;
            end
            v = 3'(i);
            iv1 = (i < 8); a1 = v[2]; b1 = v[1]; cin1 = v[0];
        end
    endtask

    task automatic test_latency(input int k, input int nseg);
        int n;
        logic [32:0] exp;
        @(negedge clk);
        rordy[k] = 1; riv[k] = 1;
        ra[k] = $urandom; rb[k] = $urandom; rcin[k] = 1'($urandom);
        exp = {1'b0, ra[k]} + {1'b0, rb[k]} + 33'(rcin[k]);
        @(negedge clk);
        riv[k] = 0;
        n = 1;
        while (!rov[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != nseg) $display("FAIL lat%0d: got %0d want %0d", k, n, nseg);
        else n_pass++;
        n_checks++;
        if ({rcout[k], rsum[k]} !== exp)
            $display("FAIL lat%0d_sum: got %h want %h", k, {rcout[k], rsum[k]}, exp);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random(input int k, input int nops);
        logic [32:0] q [$];
        logic [32:0] exp;
        int acc = 0;
        int cyc = 0;
        int bad = 0;
        logic held = 0;
        riv[k] = 0;
        while ((acc < nops || q.size() > 0) && cyc < nops * 10) begin
            @(negedge clk);
            cyc++;
            rordy[k] = ($urandom_range(3) != 0) || (acc >= nops);
            if (!held) begin
                riv[k] = (acc < nops) && ($urandom_range(3) != 0);
                ra[k] = $urandom; rb[k] = $urandom; rcin[k] = 1'($urandom);
            end
            #1;
            if (rov[k] && rordy[k]) begin
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand%0d_extra: got %h want none", k, rsum[k]);
                end else begin
                    exp = q.pop_front();
                    n_checks++;
                    if ({rcout[k], rsum[k]} !== exp) begin
                        bad++;
                        if (bad < 5)
                            $display("FAIL rand%0d: got %h want %h",
                                     k, {rcout[k], rsum[k]}, exp);
                    end else n_pass++;
                end
            end
            held = riv[k] && !rir[k];
            if (riv[k] && rir[k]) begin
                q.push_back({1'b0, ra[k]} + {1'b0, rb[k]} + 33'(rcin[k]));
                acc++;
            end
        end
        riv[k] = 0;
        n_checks++;
        if (acc != nops || q.size() != 0 || bad != 0)
            $display("FAIL rand%0d_drain: got acc %0d left %0d extra %0d want %0d 0 0",
                     k, acc, q.size(), bad, nops);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_stall();
        test_reset_mid();
        test_width1();
        test_latency(0, 5);
        test_latency(1, 3);
        test_latency(2, 1);
        test_random(0, 1500);
        test_random(1, 1500);
        test_random(2, 1500);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
